// File: rtl/reorder_buffer.sv
// reorder_buffer: 8-entry circular ROB, in-order retire of CDB results.
// Ports: issue_* (alloc at tail), busy/full/empty, cdb_* (writeback), commit_* (head retire), flush.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [DEST_W-1:0] issue_dest,
    input  logic              issue_is_store,
    output logic [2:0]        issue_idx,
    output logic [DEPTH-1:0]  busy,
    output logic              full,
    output logic              empty,
    input  logic              cdb_valid,
    input  logic [2:0]        cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [2:0]        commit_idx,
    output logic [DEST_W-1:0] commit_dest,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_is_store,
    input  logic              flush
);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  store_q;
    logic [DEST_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [2:0]        head_q;
    logic [2:0]        tail_q;
    logic [3:0]        count_q;

    logic do_issue;
    logic do_commit;
    logic do_wb;

    assign full  = (count_q == 4'(DEPTH));
    assign empty = (count_q == 4'd0);

    assign issue_idx = tail_q;
    assign busy      = busy_q;

    assign commit_valid    = busy_q[head_q] && ready_q[head_q];
    assign commit_idx      = head_q;
    assign commit_dest     = dest_q[head_q];
    assign commit_data     = data_q[head_q];
    assign commit_is_store = store_q[head_q];

    assign do_issue  = issue_valid && !full;
    assign do_commit = commit_valid && commit_ready;
    // A result landing on the entry being retired this cycle is dropped.
    assign do_wb = cdb_valid && busy_q[cdb_tag]
                   && !(do_commit && (cdb_tag == head_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            ready_q <= '0;
            store_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Tail is never busy when an issue is accepted, and head != tail
            // while committing, so these writes never collide.
            if (do_issue) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                store_q[tail_q] <= issue_is_store;
                dest_q[tail_q]  <= issue_dest;
                data_q[tail_q]  <= '0;
                tail_q          <= tail_q + 3'd1;
            end
            if (do_wb) begin
                ready_q[cdb_tag] <= 1'b1;
                data_q[cdb_tag]  <= cdb_data;
            end
            if (do_commit) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + 3'd1;
            end
            if (do_issue && !do_commit) begin
                count_q <= count_q + 4'd1;
            end else if (!do_issue && do_commit) begin
                count_q <= count_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed + random stimulus against a queue model.
// The model keeps live entries in program order; outputs derive from it.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic        issue_is_store = 1'b0;
    logic [2:0]  issue_idx;
    logic [7:0]  busy;
    logic        full;
    logic        empty;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        commit_valid;
    logic        commit_ready = 1'b0;
    logic [2:0]  commit_idx;
    logic [4:0]  commit_dest;
    logic [31:0] commit_data;
    logic        commit_is_store;
    logic        flush = 1'b0;

    reorder_buffer #(.DEPTH(8), .DATA_W(32), .DEST_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_dest      (issue_dest),
        .issue_is_store  (issue_is_store),
        .issue_idx       (issue_idx),
        .busy            (busy),
        .full            (full),
        .empty           (empty),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .commit_valid    (commit_valid),
        .commit_ready    (commit_ready),
        .commit_idx      (commit_idx),
        .commit_dest     (commit_dest),
        .commit_data     (commit_data),
        .commit_is_store (commit_is_store),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [4:0]  dest;
        logic        st;
        logic        rdy;
        logic [31:0] data;
    } ent_t;

    ent_t rob[$];
    int   m_head = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    function automatic int m_tail();
        return (m_head + rob.size()) % 8;
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] b = '0;
        foreach (rob[i]) b[rob[i].idx] = 1'b1;
        return b;
    endfunction

    function automatic logic m_cv();
        return (rob.size() > 0) && rob[0].rdy;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("issue_idx", 64'(issue_idx), 64'(m_tail()));
        chk("busy", 64'(busy), 64'(m_busy()));
        chk("full", 64'(full), 64'(rob.size() == 8));
        chk("empty", 64'(empty), 64'(rob.size() == 0));
        chk("commit_valid", 64'(commit_valid), 64'(m_cv()));
        chk("commit_idx", 64'(commit_idx), 64'(m_head));
        if (m_cv()) begin
            chk("commit_dest", 64'(commit_dest), 64'(rob[0].dest));
            chk("commit_data", 64'(commit_data), 64'(rob[0].data));
            chk("commit_store", 64'(commit_is_store), 64'(rob[0].st));
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic drive(input logic iv, input logic [4:0] d, input logic st,
                         input logic cv, input logic [2:0] tag,
                         input logic [31:0] data, input logic cr,
                         input logic fl);
        int   tl;
        logic fire;
        ent_t e;
        issue_valid    = iv;
        issue_dest     = d;
        issue_is_store = st;
        cdb_valid      = cv;
        cdb_tag        = tag;
        cdb_data       = data;
        commit_ready   = cr;
        flush          = fl;
        if (fl) begin
            rob.delete();
            m_head = 0;
        end else begin
            tl   = m_tail();
            fire = m_cv() && cr;
            if (cv) begin
                foreach (rob[i]) begin
                    if (rob[i].idx == tag && !(fire && i == 0)) begin
                        rob[i].rdy  = 1'b1;
                        rob[i].data = data;
                    end
                end
            end
            if (iv && rob.size() < 8) begin
                e.idx  = 3'(tl);
                e.dest = d;
                e.st   = st;
                e.rdy  = 1'b0;
                e.data = '0;
                rob.push_back(e);
            end
            if (fire) begin
                void'(rob.pop_front());
                m_head = (m_head + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input logic cr);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, cr, 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int hd;
        #12;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_idx", 64'(issue_idx), 64'h0);
        chk("rst_cv", 64'(commit_valid), 64'h0);
        chk("rst_cidx", 64'(commit_idx), 64'h0);
        chk("rst_cdest", 64'(commit_dest), 64'h0);
        chk("rst_cdata", 64'(commit_data), 64'h0);
        chk("rst_cst", 64'(commit_is_store), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill all eight entries, then try a ninth.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i + 1), 1'(i % 2), 1'b0, '0, '0, 1'b0, 1'b0);
            chk("fill_idx", 64'(issue_idx), 64'((i + 1) % 8));
        end
        chk("fill_busy", 64'(busy), 64'hFF);
        chk("fill_full", 64'(full), 64'h1);
        drive(1'b1, 5'd9, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("ninth_busy", 64'(busy), 64'hFF);
        chk("ninth_idx", 64'(issue_idx), 64'h0);
        do_flush();

        // Out-of-order writeback, in-order retire.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 5'(10 + i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 3'd2, 32'd30, 1'b1, 1'b0);
        chk("ooo_cv2", 64'(commit_valid), 64'h0);
        drive(1'b0, '0, 1'b0, 1'b1, 3'd1, 32'd20, 1'b1, 1'b0);
        chk("ooo_cv1", 64'(commit_valid), 64'h0);
        drive(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'd10, 1'b1, 1'b0);
        chk("ooo_c0", 64'({commit_valid, commit_idx, commit_data}),
            64'({1'b1, 3'd0, 32'd10}));
        idle(1'b1);
        chk("ooo_c1", 64'({commit_valid, commit_idx, commit_data}),
            64'({1'b1, 3'd1, 32'd20}));
        idle(1'b1);
        chk("ooo_c2", 64'({commit_valid, commit_idx, commit_data}),
            64'({1'b1, 3'd2, 32'd30}));
        idle(1'b1);
        chk("ooo_empty", 64'(empty), 64'h1);

        // Backpressure on a ready head (head is entry 3 now).
        drive(1'b1, 5'd21, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 3'd3, 32'hCAFE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("bp_hold", 64'({commit_valid, commit_idx, commit_dest,
                               commit_data}),
                64'({1'b1, 3'd3, 5'd21, 32'hCAFE}));
        end
        idle(1'b1);
        chk("bp_done", 64'({empty, issue_idx}), 64'({1'b1, 3'd4}));

        // Full with simultaneous commit and issue.
        do_flush();
        for (int i = 0; i < 8; i++)
            drive(1'b1, 5'(i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'd55, 1'b0, 1'b0);
        drive(1'b1, 5'd30, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("full_cnt7", 64'($countones(busy)), 64'd7);
        drive(1'b1, 5'd30, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("full_cnt8", 64'({full, 4'($countones(busy))}),
            64'({1'b1, 4'd8}));

        // Wrap-around.
        do_flush();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            drive(1'b0, '0, 1'b0, 1'b1, 3'(i % 8), 32'(100 + i), 1'b0,
                  1'b0);
            chk("wrap_idx", 64'({commit_valid, commit_idx}),
                64'({1'b1, 3'(i % 8)}));
            idle(1'b1);
        end
        chk("wrap_empty", 64'(empty), 64'h1);

        // Flush beats concurrent issue, CDB and commit.
        do_flush();
        for (int i = 0; i < 5; i++)
            drive(1'b1, 5'(i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 3'd0, 32'd5, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 1'b0, 1'b1, 3'd2, 32'd77, 1'b1, 1'b1);
        chk("fl_state", 64'({busy, empty, issue_idx, commit_valid}),
            64'({8'h00, 1'b1, 3'd0, 1'b0}));
        drive(1'b0, '0, 1'b0, 1'b1, 3'd2, 32'd88, 1'b1, 1'b0);
        chk("fl_stale", 64'({busy, commit_valid}), 64'h0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 5'(i), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        issue_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        rob.delete();
        m_head = 0;
        chk("arst_busy", 64'({busy, empty}), 64'({8'h00, 1'b1}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] tag;
            tag = 3'($urandom_range(0, 7));
            if (rob.size() > 0 && $urandom_range(0, 9) < 7) begin
                hd  = $urandom_range(0, rob.size() - 1);
                tag = rob[hd].idx;
            end
            drive(1'($urandom_range(0, 1)), 5'($urandom),
                  1'($urandom), 1'($urandom_range(0, 1)), tag, $urandom,
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 60) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
